// File: rtl/histogram_builder_if.sv
// Pixel stream, RAM port and status bundle of histogram_builder.
// The slave modport is the builder's view; master is the driver/RAM side.
interface histogram_builder_if #(
    parameter int WIDTH = 20
);
    logic             iStart;
    logic [7:0]       iPixel;
    logic             iValid;
    logic             oReady;
    logic             iFrameEnd;
    logic [7:0]       oRdAddr;
    logic [WIDTH-1:0] iQ;
    logic [7:0]       oWrAddr;
    logic [WIDTH-1:0] oWrData;
    logic             oWE;
    logic [WIDTH-1:0] oPixelCount;
    logic             oDone;

    modport slave (
        input  iStart, iPixel, iValid, iFrameEnd, iQ,
        output oReady, oRdAddr, oWrAddr, oWrData, oWE, oPixelCount, oDone
    );

    modport master (
        output iStart, iPixel, iValid, iFrameEnd, iQ,
        input  oReady, oRdAddr, oWrAddr, oWrData, oWE, oPixelCount, oDone
    );
endinterface

// File: rtl/histogram_builder.sv
// Grey-level histogram builder: clears the bin RAM, then read-modify-writes one bin per pixel
// with two-deep write forwarding. Define HIST_SATURATE_EN to saturate bins instead of wrapping.
module histogram_builder #(
    parameter int BINS  = 256,
    parameter int WIDTH = 20
) (
    input logic                iClk,
    input logic                iRst,
    histogram_builder_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_ACCUM = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [7:0]       LAST_BIN = 8'(BINS - 1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] bin_increment(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] result;
`ifdef HIST_SATURATE_EN
        if (value == ALL_ONES) begin
            result = value;
        end else begin
            result = value + ONE;
        end
`else
        result = value + ONE;
`endif
        return result;
    endfunction

    logic [2:0]       state_r;
    logic [7:0]       clr_addr_r;
    logic [1:0]       drain_cnt_r;
    logic             ready_r;
    logic             done_r;
    logic [WIDTH-1:0] pix_cnt_r;
    logic             s1_valid_r;
    logic [7:0]       rd_addr_r;
    logic             s2_valid_r;
    logic [7:0]       s2_bin_r;
    logic             we_r;
    logic [7:0]       wr_addr_r;
    logic [WIDTH-1:0] wr_data_r;
    logic             h1_valid_r;
    logic [7:0]       h1_bin_r;
    logic [WIDTH-1:0] h1_data_r;
    logic             accept_s;
    logic [WIDTH-1:0] fwd_val_s;

    assign accept_s = bus.iValid & ready_r;

    // Pick the freshest bin value: the write issued last cycle, the one before it, else RAM data.
    // Both of those writes land too late for the RAM read of the current stage-2 pixel.
    always_comb begin
        fwd_val_s = bus.iQ;
        if (we_r && (wr_addr_r == s2_bin_r)) begin
            fwd_val_s = wr_data_r;
        end else if (h1_valid_r && (h1_bin_r == s2_bin_r)) begin
            fwd_val_s = h1_data_r;
        end else begin
            fwd_val_s = bus.iQ;
        end
    end

    // Frame control: idle, clear sweep, accumulate, fixed three-cycle drain, done pulse.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r     <= ST_IDLE;
            clr_addr_r  <= 8'd0;
            drain_cnt_r <= 2'd0;
            ready_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.iStart) begin
                        state_r    <= ST_CLEAR;
                        clr_addr_r <= 8'd0;
                    end
                end
                ST_CLEAR: begin
                    clr_addr_r <= clr_addr_r + 8'd1;
                    if (clr_addr_r == LAST_BIN) begin
                        state_r <= ST_ACCUM;
                        ready_r <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (bus.iFrameEnd) begin
                        state_r     <= ST_DRAIN;
                        ready_r     <= 1'b0;
                        drain_cnt_r <= 2'd0;
                    end
                end
                ST_DRAIN: begin
                    // A pixel taken on the frame-end edge commits exactly three edges later.
                    if (drain_cnt_r == 2'd2) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Accepted-pixel counter, restarted by a honoured start and saturating at all-ones.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            pix_cnt_r <= ZERO;
        end else if ((state_r == ST_IDLE) && bus.iStart) begin
            pix_cnt_r <= ZERO;
        end else if (accept_s && (pix_cnt_r != ALL_ONES)) begin
            pix_cnt_r <= pix_cnt_r + ONE;
        end else begin
            pix_cnt_r <= pix_cnt_r;
        end
    end

    // Read-modify-write pipeline, clear writes and the older write-history slot.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1_valid_r <= 1'b0;
            rd_addr_r  <= 8'd0;
            s2_valid_r <= 1'b0;
            s2_bin_r   <= 8'd0;
            we_r       <= 1'b0;
            wr_addr_r  <= 8'd0;
            wr_data_r  <= ZERO;
            h1_valid_r <= 1'b0;
            h1_bin_r   <= 8'd0;
            h1_data_r  <= ZERO;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                rd_addr_r <= bus.iPixel;
            end
            s2_valid_r <= s1_valid_r;
            s2_bin_r   <= rd_addr_r;
            h1_valid_r <= we_r;
            h1_bin_r   <= wr_addr_r;
            h1_data_r  <= wr_data_r;
            if (s2_valid_r) begin
                we_r      <= 1'b1;
                wr_addr_r <= s2_bin_r;
                wr_data_r <= bin_increment(fwd_val_s);
            end else if (state_r == ST_CLEAR) begin
                we_r      <= 1'b1;
                wr_addr_r <= clr_addr_r;
                wr_data_r <= ZERO;
            end else begin
                we_r <= 1'b0;
            end
        end
    end

    assign bus.oReady      = ready_r;
    assign bus.oDone       = done_r;
    assign bus.oPixelCount = pix_cnt_r;
    assign bus.oRdAddr     = rd_addr_r;
    assign bus.oWrAddr     = wr_addr_r;
    assign bus.oWrData     = wr_data_r;
    assign bus.oWE         = we_r;
endmodule

// File: doc/histogram_builder.md
# histogram_builder

Builds the 256-bin, 20-bit grey-level histogram of one camera frame into the histogram dual-port RAM. It clears the RAM, then increments one bin per accepted 8-bit pixel using a pipelined read-modify-write with hazard forwarding. When the last increment has committed it pulses `oDone`. It sits directly upstream of `CumulativeHistogram`: `oDone` drives that block's `iStart`, and both blocks share the same RAM.

## Interface
- `BINS`, 256: number of bins; fixed to match the 8-bit address.
- `WIDTH`, 20: bin counter width.
- `iClk` in 1: clock; all logic is on the rising edge.
- `iRst` in 1: synchronous reset, active-high.
- `iStart` in 1: single-cycle strobe; begins clear plus accumulation. Honoured only in IDLE.
- `iPixel` in 8: grey-level sample.
- `iValid` in 1: `iPixel` is valid this cycle.
- `oReady` out 1: block accepts pixels. A pixel is accepted on any edge where `iValid & oReady`.
- `iFrameEnd` in 1: single-cycle strobe, honoured only in ACCUM. A pixel accepted on the same edge is counted.
- `oRdAddr` out 8: RAM read-port address. The RAM has 1-cycle read latency and returns old data on a read-during-write.
- `iQ` in 20: RAM read data.
- `oWrAddr` out 8, `oWrData` out 20, `oWE` out 1: RAM write port, all registered.
- `oPixelCount` out 20: number of pixels accepted since `iStart`.
- `oDone` out 1: one-cycle pulse once all writes have committed.

## Operation
- **Reset:** all outputs are 0 and state is IDLE. Reset mid-operation aborts immediately: no further writes, and RAM contents are unspecified.
- **States:**
  - IDLE → CLEAR on `iStart`. `oPixelCount` is cleared on the same edge.
  - CLEAR: `oWE`=1, `oWrData`=0, `oWrAddr` steps 0..255, one address per cycle. After address 255 is issued → ACCUM.
  - ACCUM: `oReady`=1. → DRAIN on `iFrameEnd`.
  - DRAIN: `oReady`=0. Waits until the pipeline is empty and the last write has committed → DONE.
  - DONE: `oDone`=1 for one cycle → IDLE.
- **Pipeline for a pixel P accepted at edge t:**
  - Edge t: `oRdAddr`<=P.
  - Edge t+1: RAM captures the read; stage-2 register <= P.
  - Edge t+2: `oWrAddr`<=P, `oWrData`<=V+1, `oWE`<=1.
  - Edge t+3: the write commits.
- **Forwarding:** V is iQ unless P matches a recent write.
  - The reads of the two previous pixels' bins are stale (one read collided with a commit, one preceded it).
  - A history of the last two issued writes is held, each as (bin, value, valid).
  - V = value of the newest matching valid entry, otherwise `iQ`.
- **Arithmetic:** increment is WIDTH bits. Saturation depends on `HIST_SATURATE_EN` (see Configuration).
- **`oPixelCount`:** saturates at 2^20−1 regardless of configuration.
- **Ignored inputs:**
  - `iValid` and `iFrameEnd` outside ACCUM.
  - `iStart` outside IDLE.
- **`oWE` outside CLEAR and ACCUM/DRAIN write slots:** 0.

## Timing
- Pixel to write strobe: 2 cycles. Pixel to commit: 3 cycles.
- Throughput: one pixel per cycle, sustained, including runs of identical bins.
- CLEAR takes exactly 256 cycles. The first pixel can be accepted on the edge after `oWrAddr`=255 is issued.
- `oDone` rises 3 cycles after the `iFrameEnd` edge if a pixel was accepted on that edge. It rises no later than that in any case.
- `iFrameEnd` with zero pixels accepted: DRAIN lasts 3 cycles, then `oDone`.
- After `oDone`, the RAM holds the final counts, so `CumulativeHistogram` may read it from the next cycle.

## Configuration
- `HIST_SATURATE_EN` defined: a bin at 20'hFFFFF stays at 20'hFFFFF when incremented.
- Undefined: the bin wraps to 0.
- Forwarded values follow the same rule.

## Test plan
- **Clear:** preload RAM with 20'hABCDE everywhere, pulse `iStart`, then `iFrameEnd` immediately after CLEAR → all 256 bins read 0, `oPixelCount`=0, `oDone` pulses once.
- **Hazard run:** 10 consecutive pixels of 0x37, then 0x37, 0x38, 0x37, 0x38 → bin 0x37=12, bin 0x38=2, all others 0.
- **Ramp:** pixel stream i mod 256 for 307200 pixels with `iValid` held high → every bin = 1200, `oPixelCount`=307200.
- **Random bubbles:** random `iValid` gaps with random pixels → RAM matches a software histogram exactly.
- **Saturation:** preload bin 5 with 20'hFFFFE, skip CLEAR via forced state, send three pixels of 5 → bin 5 = 20'hFFFFF with `HIST_SATURATE_EN`, 20'h00001 without.
- **Reset mid-frame:** assert `iRst` during ACCUM → next cycle `oWE`=0, `oReady`=0, `oDone`=0, state IDLE; a new `iStart` then runs a full frame correctly.
